// File: rtl/sub_pkg.sv
// Shared types and helpers for the chunked borrow subtractor.
// FSM state encoding and chunk-index width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/borrow_lookahead_chunk.sv
// Combinational CHUNK-bit subtract slice.
// Borrows come from G/P prefix terms rather than a ripple chain.
module borrow_lookahead_chunk
  import sub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   brw;
  logic             pp;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Flattened lookahead: borrow i is OR of each generate below it
  // propagated through the bits in between, plus the chunk borrow-in.
  always_comb begin
    brw = '0;
    pp  = 1'b1;
    for (int i = 0; i <= CHUNK; i++) begin
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        brw[i] = brw[i] | (g[j] & pp);
        pp     = pp & p[j];
      end
      brw[i] = brw[i] | (pp & bin);
    end
  end

  assign d    = a ^ b ^ brw[CHUNK-1:0];
  assign bout = brw[CHUNK];

endmodule

// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle A - B - BorrowIn, one CHUNK per clock, LSB first.
// Registered borrow links chunks; handshakes on input and output.
module chunked_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Difference,
  output logic             BorrowOut,
  output logic             Overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = idx_w(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 2) begin : g_bad_params
    $error("WIDTH must be a multiple of CHUNK with at least 2 chunks");
  end

  state_e state_q, state_d;

  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0] b_q, b_d;
  logic [NCHUNK-1:0][CHUNK-1:0] diff_q, diff_d;

  logic          brw_q, brw_d;
  logic [KW-1:0] k_q, k_d;
  logic          bo_q, bo_d;
  logic          ov_q, ov_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;

  logic [CHUNK-1:0] ch_d;
  logic             ch_bo;

  borrow_lookahead_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_q[k_q]),
    .b   (b_q[k_q]),
    .bin (brw_q),
    .d   (ch_d),
    .bout(ch_bo)
  );

  // Next-state: accept, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    k_d     = k_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          a_d     = A;
          b_d     = B;
          brw_d   = BorrowIn;
          diff_d  = '0;
          k_d     = '0;
          bo_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[k_q] = ch_d;
        brw_d       = ch_bo;
        if (k_q == K_LAST) begin
          bo_d    = ch_bo;
          ov_d    = (a_q[NCHUNK-1][CHUNK-1] != b_q[NCHUNK-1][CHUNK-1])
                 && (ch_d[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
    vld_d = (state_d == DONE);
  end

  // State, operand and result registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      k_q     <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      k_q     <= k_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign InReady    = rdy_q;
  assign OutValid   = vld_q;
  assign Difference = diff_q;
  assign BorrowOut  = bo_q;
  assign Overflow   = ov_q;

endmodule
